// File: rtl/down_counter_timer_pkg.sv
// ----------------------------------------------------------------------------
// down_counter_timer_pkg
//   Shared definitions for the loadable down-counter / countdown timer.
//   - DEFAULT_WIDTH : default width of count, load value and reload register
//   - state_t       : controller state encoding (IDLE / RUN / DONE)
// ----------------------------------------------------------------------------
package down_counter_timer_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : down_counter_timer_pkg

// File: rtl/down_counter_timer_if.sv
// ----------------------------------------------------------------------------
// down_counter_timer_if
//   Control/status bundle for down_counter_timer.
//
//   Handshake semantics: there is no valid/ready pair on this block. Every
//   command input (load, start, stop, enable, auto_reload) is a level that is
//   sampled on each rising clock edge; a command held for N edges is acted on
//   N times. Command priority on a single edge is stop > load > start > count.
//   All status outputs (count, tc, busy, done, dbg_state) are registered.
//
//   Signals
//     load        master->slave  capture load_val
//     load_val    master->slave  value to load (WIDTH bits)
//     start       master->slave  begin counting from the current count
//     stop        master->slave  abort counting, hold count
//     enable      master->slave  count qualifier
//     auto_reload master->slave  1 = periodic, 0 = one-shot
//     count       slave->master  current count value
//     tc          slave->master  one-cycle terminal-count pulse
//     busy        slave->master  1 while in RUN
//     done        slave->master  1 while in DONE
//     dbg_state   slave->master  controller state, for observation only
// ----------------------------------------------------------------------------
interface down_counter_timer_if
    #(parameter int WIDTH = down_counter_timer_pkg::DEFAULT_WIDTH);

    import down_counter_timer_pkg::*;

    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             start;
    logic             stop;
    logic             enable;
    logic             auto_reload;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             busy;
    logic             done;
    state_t           dbg_state;

    // Controller side (software / FSM driving the timer)
    modport master (
        output load, load_val, start, stop, enable, auto_reload,
        input  count, tc, busy, done, dbg_state
    );

    // Timer side
    modport slave (
        input  load, load_val, start, stop, enable, auto_reload,
        output count, tc, busy, done, dbg_state
    );

endinterface : down_counter_timer_if

// File: rtl/down_counter_timer.sv
// ----------------------------------------------------------------------------
// down_counter_timer
//   Loadable down-counter / countdown timer. A start value is loaded, counting
//   is started, and the count decrements on every enabled clock. On the edge
//   where the count leaves 1 a registered one-cycle tc pulse is produced and
//   the timer either stops in DONE (one-shot) or reloads from the reload
//   register and keeps running (periodic).
//
//   Ports
//     clk    : single clock, all state changes on its rising edge
//     reset  : asynchronous, active-high reset
//     bus    : down_counter_timer_if.slave (commands in, status out)
//
//   Parameters
//     WIDTH  : width of count, load_val and the reload register
// ----------------------------------------------------------------------------
module down_counter_timer
    import down_counter_timer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    down_counter_timer_if.slave  bus
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t           r_state;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_reload;
    logic             r_tc;
    logic             r_busy;
    logic             r_done;

    // ------------------------------------------------------------------
    // Next-state values
    // ------------------------------------------------------------------
    state_t           w_state_nxt;
    logic [WIDTH-1:0] w_count_nxt;
    logic [WIDTH-1:0] w_reload_nxt;
    logic             w_tc_nxt;

    // Count that a start on this edge would run from: a simultaneous load
    // takes effect first, so load+start begins at load_val.
    logic [WIDTH-1:0] w_eff_count;
    // Enabled edge on which the count leaves 1 (only meaningful in RUN).
    logic             w_terminal;
    // Periodic reload is possible only with a non-zero reload value;
    // a zero reload would otherwise spin in RUN without ever counting.
    logic             w_can_reload;

    assign w_eff_count  = bus.load ? bus.load_val : r_count;
    assign w_terminal   = bus.enable && (r_count == WIDTH'(1));
    assign w_can_reload = bus.auto_reload && (r_reload != '0);

    // ------------------------------------------------------------------
    // Next-state / datapath logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_count_nxt  = r_count;
        w_reload_nxt = r_reload;
        w_tc_nxt     = 1'b0;

        case (r_state)
            RUN: begin
                if (bus.stop) begin
                    // Abort: count holds, load/start/count are all overridden.
                    w_state_nxt = IDLE;
                end else begin
                    // A load while running only retargets the next reload.
                    if (bus.load) begin
                        w_reload_nxt = bus.load_val;
                    end
                    if (w_terminal) begin
                        w_tc_nxt = 1'b1;
                        if (w_can_reload) begin
                            w_count_nxt = r_reload;
                        end else begin
                            w_count_nxt = '0;
                            w_state_nxt = DONE;
                        end
                    end else if (bus.enable && (r_count != '0)) begin
                        // Gated so the count can never wrap below zero.
                        w_count_nxt = r_count - WIDTH'(1);
                    end
                end
            end

            IDLE, DONE: begin
                // stop is meaningless outside RUN and is ignored here.
                if (bus.load) begin
                    w_reload_nxt = bus.load_val;
                    w_count_nxt  = bus.load_val;
                    w_state_nxt  = IDLE;
                end
                if (bus.start && (w_eff_count != '0)) begin
                    w_state_nxt = RUN;
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_count  <= '0;
            r_reload <= '0;
            r_tc     <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_count  <= w_count_nxt;
            r_reload <= w_reload_nxt;
            r_tc     <= w_tc_nxt;
            // Status flags registered from the next state so they line up
            // with r_state without a decode path on the outputs.
            r_busy   <= (w_state_nxt == RUN);
            r_done   <= (w_state_nxt == DONE);
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.count     = r_count;
    assign bus.tc        = r_tc;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.dbg_state = r_state;

endmodule : down_counter_timer
